fetch_unit: RTL

Instruction-fetch stage and IF/ID pipeline register of the RISC-V core. It owns the PC, issues requests to the instruction cache, absorbs cache misses, and applies the hazard unit's PC_Stall/NOP_Ins controls and branch/jump redirects. It feeds the decoder and the hazard unit with the IF/ID instruction, its PC and its register fields.

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register for the RISC-V core.
// Owns the PC and absorbs cache misses, hazard stalls, bubbles and redirects.
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            PC_Stall,
  input  logic            NOP_Ins,
  input  logic            pc_change,
  input  logic [XLEN-1:0] pc_target,
  output logic            i_req,
  output logic [XLEN-1:0] i_addr,
  input  logic [31:0]     i_rdata,
  input  logic            i_stall,
  output logic [31:0]     IF_ID_instr,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic            IF_ID_valid,
  output logic [4:0]      IF_ID_rs1,
  output logic [4:0]      IF_ID_rs2,
  output logic [4:0]      IF_ID_rd
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    MISS  = 2'b01,
    HOLD  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  state_t            state, state_n;
  logic [XLEN-1:0]   pc, pc_n;
  logic [XLEN-1:0]   redir_pc, redir_n;
  logic [31:0]       skid_instr, skid_instr_n;
  logic [XLEN-1:0]   skid_pc, skid_pc_n;
  logic              skid_valid, skid_valid_n;
  logic [31:0]       instr_n;
  logic [XLEN-1:0]   ifpc_n;
  logic              valid_n;
  logic [4:0]        rs1_n, rs2_n, rd_n;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   target_al;

  assign pc_plus4  = pc + PC_STEP;
  assign target_al = pc_target & ALIGN_MASK;

  // i_req is qualified by rst_n so it stays low for the whole reset window.
  assign i_req  = rst_n && (state != HOLD);
  assign i_addr = pc;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    redir_n      = redir_pc;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    skid_valid_n = skid_valid;
    instr_n      = IF_ID_instr;
    ifpc_n       = IF_ID_pc;
    valid_n      = IF_ID_valid;

    if (pc_change) begin
      instr_n      = NOP_INSTR;
      valid_n      = 1'b0;
      skid_valid_n = 1'b0;
      // An outstanding request still owes a response: keep its address on
      // the bus, park the target and discard the response when it arrives.
      if ((state != HOLD) && i_stall) begin
        redir_n = target_al;
        state_n = DRAIN;
      end else begin
        pc_n    = target_al;
        state_n = FETCH;
      end
    end else begin
      case (state)
        FETCH, MISS: begin
          if (i_stall) begin
            state_n = MISS;
            if (!PC_Stall) begin
              instr_n = NOP_INSTR;
              valid_n = 1'b0;
            end
          end else if (PC_Stall || NOP_Ins) begin
            // Response is valid now but IF/ID cannot take it: park it.
            skid_instr_n = i_rdata;
            skid_pc_n    = pc;
            skid_valid_n = 1'b1;
            pc_n         = pc_plus4;
            state_n      = HOLD;
            if (!PC_Stall) begin
              instr_n = NOP_INSTR;
              valid_n = 1'b0;
            end
          end else begin
            instr_n = i_rdata;
            ifpc_n  = pc;
            valid_n = 1'b1;
            pc_n    = pc_plus4;
            state_n = FETCH;
          end
        end
        HOLD: begin
          if (!PC_Stall) begin
            if (NOP_Ins) begin
              instr_n = NOP_INSTR;
              valid_n = 1'b0;
            end else begin
              instr_n      = skid_instr;
              ifpc_n       = skid_pc;
              valid_n      = skid_valid;
              skid_valid_n = 1'b0;
              state_n      = FETCH;
            end
          end
        end
        DRAIN: begin
          if (!i_stall) begin
            pc_n    = redir_pc;
            state_n = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end

    rs1_n = valid_n ? instr_n[19:15] : '0;
    rs2_n = valid_n ? instr_n[24:20] : '0;
    rd_n  = valid_n ? instr_n[11:7]  : '0;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redir_pc    <= '0;
      skid_instr  <= NOP_INSTR;
      skid_pc     <= '0;
      skid_valid  <= 1'b0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_pc    <= '0;
      IF_ID_valid <= 1'b0;
      IF_ID_rs1   <= '0;
      IF_ID_rs2   <= '0;
      IF_ID_rd    <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      redir_pc    <= redir_n;
      skid_instr  <= skid_instr_n;
      skid_pc     <= skid_pc_n;
      skid_valid  <= skid_valid_n;
      IF_ID_instr <= instr_n;
      IF_ID_pc    <= ifpc_n;
      IF_ID_valid <= valid_n;
      IF_ID_rs1   <= rs1_n;
      IF_ID_rs2   <= rs2_n;
      IF_ID_rd    <= rd_n;
    end
  end

endmodule
